// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Holds FSM states, grant encoding and default depth.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam int MEM_DEPTH_DEFAULT = 526;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker.
// Ports: i_req, d_req, last_grant in; grant out (GNT_I/GNT_D).
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = GNT_I;
        if (i_req && d_req) begin
            // On conflict, favour whoever did not win last time.
            grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory.
// Ports: CLK, RST (async, active-high); i_req/i_addr -> i_ack,
// i_rdata, i_err; d_req/d_we/d_addr/d_wdata -> d_ack, d_rdata,
// d_err; memory side MRA, MWE, MWD out, MRD in; busy.
// Optional range check: define MEM_ARB_RANGE_CHK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        i_err,
    output logic        d_err,
    output logic [31:0] MRA,
    output logic        MWE,
    output logic [31:0] MWD,
    input  logic [31:0] MRD,
    output logic        busy
);

    state_e      r_state;
    state_e      w_next;
    logic        r_last_grant;
    logic        r_win;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        w_grant;
    logic        w_any_req;
    logic        w_oor;

    assign w_any_req = i_req | d_req;

    mem_arb_rr u_rr (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

`ifdef MEM_ARB_RANGE_CHK_EN
    assign w_oor = (r_addr >= 32'(MEM_DEPTH));
`else
    assign w_oor = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any_req) w_next = ACCESS;
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_grant <= GNT_D;
            r_win        <= GNT_I;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_win        <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == GNT_D) begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_wdata <= d_wdata;
                end else begin
                    r_addr  <= i_addr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if (r_state == ACCESS) begin
                if (r_win == GNT_I) begin
                    r_i_rdata <= w_oor ? '0 : MRD;
                end else begin
                    // Stores report zero read data.
                    r_d_rdata <= (r_we || w_oor) ? '0 : MRD;
                end
            end
        end
    end

    // Combinational so an async reset drops the strobe at once.
    assign MWE     = (r_state == ACCESS) && r_we && !w_oor;
    assign MRA     = r_addr;
    assign MWD     = r_wdata;
    assign i_ack   = (r_state == DONE) && (r_win == GNT_I);
    assign d_ack   = (r_state == DONE) && (r_win == GNT_D);
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign busy    = (r_state != IDLE);

`ifdef MEM_ARB_RANGE_CHK_EN
    assign i_err = i_ack && w_oor;
    assign d_err = d_ack && w_oor;
`else
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a memory model
// and a scoreboard queue of expected acks.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, i_err, d_err, MWE, busy;
    logic [31:0] i_rdata, d_rdata, MRA, MWD, MRD;

    mem_port_arbiter #(.MEM_DEPTH(526)) dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .i_err(i_err), .d_err(d_err),
        .MRA(MRA), .MWE(MWE), .MWD(MWD), .MRD(MRD),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:1023];
    assign MRD = mem[MRA[9:0]];
    always @(posedge CLK) if (MWE) mem[MRA[9:0]] <= MWD;

    int mwe_cnt = 0;
    always @(posedge CLK) if (MWE) mwe_cnt <= mwe_cnt + 1;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    int compared = 0;
    int mismatched = 0;
    logic [31:0] last_d;

    task automatic wait_ack(output int lat, output logic got);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 12) begin
            @(negedge CLK);
            lat++;
            got = i_ack | d_ack;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(negedge CLK);
        compared++;
        if ({i_ack, d_ack, i_err, d_err, MWE, busy} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {i_ack, d_ack, i_err, d_err, MWE, busy});
        end
        compared++;
        if ({i_rdata, d_rdata, MRA, MWD} !== 128'b0) begin
            mismatched++;
            $display("FAIL reset_data got %h %h %h %h want 0",
                     i_rdata, d_rdata, MRA, MWD);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_ifetch;
        int   lat;
        logic got;
        exp_t e;
        mem[512] = 32'h8C080000;
        sbq.push_back('{1'b0, 32'h8C080000, 1'b0});
        i_addr = 512;
        i_req  = 1'b1;
        wait_ack(lat, got);
        i_req = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL ifetch_timeout no ack in %0d cycles", lat);
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            compared++;
            if (lat !== 2) begin
                mismatched++;
                $display("FAIL ifetch_latency got %0d want 2", lat);
            end
            compared++;
            if ({i_ack, d_ack} !== {~e.port, e.port}) begin
                mismatched++;
                $display("FAIL ifetch_acks got %b want 10",
                         {i_ack, d_ack});
            end
            compared++;
            if (i_rdata !== e.data || i_err !== e.err) begin
                mismatched++;
                $display("FAIL ifetch_data got %h/%b want %h/%b",
                         i_rdata, i_err, e.data, e.err);
            end
            compared++;
            if (busy !== 1'b1) begin
                mismatched++;
                $display("FAIL ifetch_busy got %b want 1", busy);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_store_load;
        int   lat;
        logic got;
        exp_t e;
        int   c0;
        c0 = mwe_cnt;
        sbq.push_back('{1'b1, 32'h0, 1'b0});
        d_we = 1'b1; d_addr = 5; d_wdata = 32'hDEADBEEF;
        d_req = 1'b1;
        wait_ack(lat, got);
        d_req = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL store_timeout no ack");
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            compared++;
            if (d_ack !== 1'b1 || i_ack !== 1'b0 ||
                d_rdata !== e.data) begin
                mismatched++;
                $display("FAIL store_ack got %b%b/%h want 01/%h",
                         i_ack, d_ack, d_rdata, e.data);
            end
        end
        @(negedge CLK);
        compared++;
        if (mwe_cnt - c0 !== 1) begin
            mismatched++;
            $display("FAIL store_mwe_cycles got %0d want 1",
                     mwe_cnt - c0);
        end
        compared++;
        if (MWE !== 1'b0 || MRA !== 32'd5 ||
            MWD !== 32'hDEADBEEF || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_hold got %b %h %h %b want 0 5 deadbeef 0",
                     MWE, MRA, MWD, busy);
        end
        sbq.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
        d_we = 1'b0;
        d_req = 1'b1;
        wait_ack(lat, got);
        d_req = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL load_timeout no ack");
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            compared++;
            if (d_ack !== 1'b1 || d_rdata !== e.data) begin
                mismatched++;
                $display("FAIL load_data got %b/%h want 1/%h",
                         d_ack, d_rdata, e.data);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_range;
        int   lat;
        logic got;
        exp_t e;
        int   c0;
        c0 = mwe_cnt;
        mem[600] = 32'h5A5A5A5A;
`ifdef MEM_ARB_RANGE_CHK_EN
        sbq.push_back('{1'b1, 32'h0, 1'b1});
        last_d = 32'h0;
`else
        sbq.push_back('{1'b1, 32'h5A5A5A5A, 1'b0});
        last_d = 32'h5A5A5A5A;
`endif
        d_we = 1'b0; d_addr = 600;
        d_req = 1'b1;
        wait_ack(lat, got);
        d_req = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL range_timeout no ack");
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            compared++;
            if (d_ack !== 1'b1 || d_err !== e.err ||
                d_rdata !== e.data) begin
                mismatched++;
                $display("FAIL range_load got %b/%b/%h want 1/%b/%h",
                         d_ack, d_err, d_rdata, e.err, e.data);
            end
        end
        compared++;
        if (mwe_cnt !== c0) begin
            mismatched++;
            $display("FAIL range_mwe got %0d writes want 0",
                     mwe_cnt - c0);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        int   lat;
        logic got;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            mem[520 + k] = 32'hA000_0000 + 32'(k);
        end
        i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 520 + k;
            sbq.push_back('{1'b0, 32'hA000_0000 + 32'(k), 1'b0});
            wait_ack(lat, got);
            if (!got) begin
                compared++; mismatched++;
                $display("FAIL b2b_timeout grant %0d", k);
                sbq.delete();
                break;
            end
            e = sbq.pop_front();
            compared++;
            if (lat !== ((k == 0) ? 2 : 3) || d_ack !== 1'b0 ||
                i_rdata !== e.data) begin
                mismatched++;
                $display("FAIL b2b_%0d got lat %0d d_ack %b %h want %0d 0 %h",
                         k, lat, d_ack, i_rdata,
                         (k == 0) ? 2 : 3, e.data);
            end
        end
        i_req = 1'b0;
        compared++;
        if (d_rdata !== last_d) begin
            mismatched++;
            $display("FAIL b2b_dhold got %h want %h", d_rdata, last_d);
        end
        @(negedge CLK);
    endtask

    task automatic test_conflict;
        int   lat;
        logic got;
        exp_t e;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mem[513] = 32'h0000_1111;
        mem[10]  = 32'h0000_2222;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sbq.push_back('{1'b0, 32'h0000_1111, 1'b0});
            else            sbq.push_back('{1'b1, 32'h0000_2222, 1'b0});
        end
        i_addr = 513; d_addr = 10; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(lat, got);
            if (!got) begin
                compared++; mismatched++;
                $display("FAIL conflict_timeout grant %0d", k);
                break;
            end
            e = sbq.pop_front();
            compared++;
            if ((i_ack && d_ack) || d_ack !== e.port ||
                (e.port ? d_rdata : i_rdata) !== e.data) begin
                mismatched++;
                $display("FAIL conflict_%0d got acks %b%b data %h want port %b data %h",
                         k, i_ack, d_ack,
                         e.port ? d_rdata : i_rdata, e.port, e.data);
            end
        end
        sbq.delete();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_abort;
        int acks;
        mem[7] = 32'h1111_1111;
        d_we = 1'b1; d_addr = 7; d_wdata = 32'hCAFEF00D;
        d_req = 1'b1;
        @(negedge CLK);
        compared++;
        if (MWE !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_access got MWE %b busy %b want 1 1",
                     MWE, busy);
        end
        RST = 1'b1;
        d_req = 1'b0;
        #1;
        compared++;
        if ({i_ack, d_ack, i_err, d_err, MWE, busy} !== 6'b0 ||
            {i_rdata, d_rdata, MRA, MWD} !== 128'b0) begin
            mismatched++;
            $display("FAIL abort_outputs got %b %h %h %h %h want 0",
                     {i_ack, d_ack, i_err, d_err, MWE, busy},
                     i_rdata, d_rdata, MRA, MWD);
        end
        @(negedge CLK);
        RST = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge CLK);
            if (i_ack || d_ack) acks++;
        end
        compared++;
        if (acks !== 0) begin
            mismatched++;
            $display("FAIL abort_noack got %0d acks want 0", acks);
        end
        compared++;
        if (mem[7] !== 32'h1111_1111) begin
            mismatched++;
            $display("FAIL abort_mem got %h want 11111111", mem[7]);
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_store_load();
        test_range();
        test_back_to_back();
        test_conflict();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
